// File: rtl/uart_init_sequencer.sv
// Wishbone master that programs a 16550-style UART (LCR/DLL/DLM/FCR/IER) after reset or on request.
// Build macro UART_INIT_READBACK_EN adds a final LCR readback check before declaring success.
module uart_init_sequencer #(
    parameter logic [15:0] DIVISOR    = 16'h001B,
    parameter logic [7:0]  LCR_VALUE  = 8'h03,
    parameter logic [7:0]  FCR_VALUE  = 8'hC7,
    parameter logic [7:0]  IER_VALUE  = 8'h00,
    parameter int          TIMEOUT    = 64,
    parameter int          AUTO_START = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       start_i,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LCR_DLAB = 4'd1;
    localparam logic [3:0] S_DLL      = 4'd2;
    localparam logic [3:0] S_DLM      = 4'd3;
    localparam logic [3:0] S_LCR      = 4'd4;
    localparam logic [3:0] S_FCR      = 4'd5;
    localparam logic [3:0] S_IER      = 4'd6;
`ifdef UART_INIT_READBACK_EN
    localparam logic [3:0] S_CHECK    = 4'd7;
`endif
    localparam logic [3:0] S_GAP      = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;
    localparam logic [3:0] S_ERROR    = 4'd10;

    localparam logic [7:0] LCR_DLAB_VAL   = LCR_VALUE | 8'h80;
    localparam logic [7:0] LCR_RUN_VAL    = LCR_VALUE & 8'h7F;
    localparam logic [9:0] TO_LAST        = 10'(TIMEOUT - 1);
    localparam logic       AUTO_START_BIT = (AUTO_START != 0) ? 1'b1 : 1'b0;

    logic [3:0] state_q, state_d;
    logic [3:0] ret_q, ret_d;
    logic [9:0] cnt_q, cnt_d;
    logic       auto_q;
    logic       cyc_q, cyc_d;
    logic       we_q, we_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ack_s;
    logic       go_s;
    logic       timeout_s;

    function automatic logic [3:0] follow(input logic [3:0] s);
        case (s)
            S_LCR_DLAB: follow = S_DLL;
            S_DLL:      follow = S_DLM;
            S_DLM:      follow = S_LCR;
            S_LCR:      follow = S_FCR;
            S_FCR:      follow = S_IER;
`ifdef UART_INIT_READBACK_EN
            S_IER:      follow = S_CHECK;
`else
            S_IER:      follow = S_DONE;
`endif
            default:    follow = S_ERROR;
        endcase
    endfunction

    // An ack only counts while a cycle is actually open on the bus.
    assign ack_s     = wb_ack_i & cyc_q;
    assign go_s      = start_i | auto_q;
    assign timeout_s = (cnt_q == TO_LAST);

`ifdef UART_INIT_READBACK_EN
    logic rb_ok_s;
    assign rb_ok_s = (wb_dat_i == LCR_RUN_VAL);
`else
    logic unused_rd_s;
    assign unused_rd_s = ^wb_dat_i;
`endif

    // Sequencing: walk the register list with one idle GAP cycle after each access.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go_s) begin
                    state_d = S_LCR_DLAB;
                    cnt_d   = 10'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LCR_DLAB, S_DLL, S_DLM, S_LCR, S_FCR, S_IER: begin
                if (ack_s) begin
                    state_d = S_GAP;
                    ret_d   = follow(state_q);
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
`ifdef UART_INIT_READBACK_EN
            S_CHECK: begin
                if (ack_s) begin
                    state_d = rb_ok_s ? S_DONE : S_ERROR;
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
`endif
            S_GAP: begin
                state_d = ret_q;
                cnt_d   = 10'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status drive decoded from the state being entered, so outputs line up with the state.
    always_comb begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = 3'd0;
        dat_d = 8'd0;
        case (state_d)
            S_LCR_DLAB: begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd3; dat_d = LCR_DLAB_VAL;   end
            S_DLL:      begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd0; dat_d = DIVISOR[7:0];   end
            S_DLM:      begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd1; dat_d = DIVISOR[15:8];  end
            S_LCR:      begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd3; dat_d = LCR_RUN_VAL;    end
            S_FCR:      begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd2; dat_d = FCR_VALUE;      end
            S_IER:      begin cyc_d = 1'b1; we_d = 1'b1; adr_d = 3'd1; dat_d = IER_VALUE;      end
`ifdef UART_INIT_READBACK_EN
            S_CHECK:    begin cyc_d = 1'b1; we_d = 1'b0; adr_d = 3'd3; dat_d = 8'd0;           end
`endif
            default:    begin cyc_d = 1'b0; we_d = 1'b0; adr_d = 3'd0; dat_d = 8'd0;           end
        endcase
        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    // State and output registers; auto_q makes the first post-reset cycle behave as a start.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            cnt_q   <= 10'd0;
            auto_q  <= AUTO_START_BIT;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            auto_q  <= 1'b0;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_uart_init_sequencer.sv
// Scoreboard bench: dut 0 uses default parameters (auto start), dut 1 uses custom values,
// TIMEOUT=8 and AUTO_START=0. Expected bus accesses come from a table-level model.
`timescale 1ns/1ps
module tb_uart_init_sequencer;

    localparam logic [15:0] DIV_A = 16'h001B;
    localparam logic [7:0]  LCR_A = 8'h03;
    localparam logic [7:0]  FCR_A = 8'hC7;
    localparam logic [7:0]  IER_A = 8'h00;
    localparam int          TO_A  = 64;
    localparam logic [15:0] DIV_B = 16'hA5C3;
    localparam logic [7:0]  LCR_B = 8'h9B;
    localparam logic [7:0]  FCR_B = 8'h81;
    localparam logic [7:0]  IER_B = 8'h0F;
    localparam int          TO_B  = 8;
`ifdef UART_INIT_READBACK_EN
    localparam int N_ACC = 7;
`else
    localparam int N_ACC = 6;
`endif

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] dat;
        logic       we;
        logic       to;
    } xact_t;

    logic       clk;
    logic       rst_n  [2];
    logic       start  [2] = '{1'b0, 1'b0};
    logic [2:0] adr    [2];
    logic [7:0] dat_o  [2];
    logic [7:0] rd_val [2] = '{8'h00, 8'h00};
    logic       we     [2];
    logic       stb    [2];
    logic       cyc    [2];
    logic       ack    [2] = '{1'b0, 1'b0};
    logic       busy   [2];
    logic       done   [2];
    logic       err    [2];

    int n_tests = 0;
    int n_fail  = 0;

    xact_t exp_q0[$];
    xact_t exp_q1[$];

    int   stall [2] = '{-1, -1};
    logic zero_wait = 1'b0;
    logic noise     = 1'b0;

    uart_init_sequencer u_dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[0]), .start_i(start[0]),
        .wb_adr_o(adr[0]), .wb_dat_o(dat_o[0]), .wb_dat_i(rd_val[0]),
        .wb_we_o(we[0]), .wb_stb_o(stb[0]), .wb_cyc_o(cyc[0]), .wb_ack_i(ack[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
    );

    uart_init_sequencer #(
        .DIVISOR(DIV_B), .LCR_VALUE(LCR_B), .FCR_VALUE(FCR_B), .IER_VALUE(IER_B),
        .TIMEOUT(TO_B), .AUTO_START(0)
    ) u_dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n[1]), .start_i(start[1]),
        .wb_adr_o(adr[1]), .wb_dat_o(dat_o[1]), .wb_dat_i(rd_val[1]),
        .wb_we_o(we[1]), .wb_stb_o(stb[1]), .wb_cyc_o(cyc[1]), .wb_ack_i(ack[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(int d, string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", d, name, act, exp);
        end
    endfunction

    function automatic void push_exp(int d, xact_t x);
        if (d == 0) exp_q0.push_back(x); else exp_q1.push_back(x);
    endfunction

    function automatic int exp_size(int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic xact_t pop_exp(int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic logic [7:0] lcr_of(int d);
        return (d == 0) ? LCR_A : LCR_B;
    endfunction

    // Reference: i-th bus access of the init sequence, straight from the register table.
    function automatic xact_t ref_access(int d, int i);
        logic [15:0] dv;
        logic [7:0]  lcr;
        xact_t       x;
        dv  = (d == 0) ? DIV_A : DIV_B;
        lcr = lcr_of(d);
        x.to = 1'b0;
        x.we = 1'b1;
        case (i)
            0:       begin x.adr = 3'd3; x.dat = lcr | 8'h80; end
            1:       begin x.adr = 3'd0; x.dat = dv[7:0]; end
            2:       begin x.adr = 3'd1; x.dat = dv[15:8]; end
            3:       begin x.adr = 3'd3; x.dat = lcr & 8'h7F; end
            4:       begin x.adr = 3'd2; x.dat = (d == 0) ? FCR_A : FCR_B; end
            5:       begin x.adr = 3'd1; x.dat = (d == 0) ? IER_A : IER_B; end
            default: begin x.adr = 3'd3; x.dat = 8'h00; x.we = 1'b0; end
        endcase
        return x;
    endfunction

    function automatic void model_seq(int d, int stall_at);
        xact_t x;
        for (int i = 0; i < N_ACC; i++) begin
            x = ref_access(d, i);
            if (i == stall_at) begin
                x.to = 1'b1;
                push_exp(d, x);
                break;
            end
            push_exp(d, x);
        end
    endfunction

    function automatic logic model_err(int d, int stall_at);
        if (stall_at >= 0 && stall_at < N_ACC) return 1'b1;
`ifdef UART_INIT_READBACK_EN
        if (rd_val[d] != (lcr_of(d) & 8'h7F)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Slave model: random wait states, optional never-ack access, stray acks while bus idle.
    int   s_idx   [2] = '{0, 0};
    int   s_wcnt  [2] = '{0, 0};
    int   s_delay [2] = '{0, 0};
    logic s_cyc   [2] = '{1'b0, 1'b0};
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && s_cyc[d]) s_idx[d] = s_idx[d] + 1;
            if (!busy[d]) s_idx[d] = 0;
            if (cyc[d] && stb[d]) begin
                if (s_idx[d] == stall[d]) begin
                    ack[d] = 1'b0;
                end else if (s_wcnt[d] >= s_delay[d]) begin
                    ack[d] = 1'b1;
                end else begin
                    ack[d] = 1'b0;
                    s_wcnt[d] = s_wcnt[d] + 1;
                end
            end else begin
                ack[d]     = noise && ($urandom_range(0, 3) == 0);
                s_wcnt[d]  = 0;
                s_delay[d] = zero_wait ? 0 : int'($urandom_range(0, 3));
            end
            s_cyc[d] = cyc[d];
        end
    end

    // Monitor: pops the scoreboard on every completed or timed-out access.
    logic        m_prev [2] = '{1'b0, 1'b0};
    logic        m_comp [2] = '{1'b0, 1'b0};
    int          m_run  [2] = '{0, 0};
    logic [11:0] m_hold [2];

    function automatic void score(int d, logic is_to);
        xact_t x;
        check(d, "xact_expected", 32'(exp_size(d) > 0), 32'd1);
        if (exp_size(d) > 0) begin
            x = pop_exp(d);
            check(d, "xact_timeout_kind", 32'(is_to), 32'(x.to));
            check(d, "xact_adr_we", 32'({m_hold[d][11:9], m_hold[d][0]}), 32'({x.adr, x.we}));
            if (x.we) check(d, "xact_dat", 32'(m_hold[d][8:1]), 32'(x.dat));
            if (is_to) check(d, "timeout_len", 32'(m_run[d]), 32'((d == 0) ? TO_A : TO_B));
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_prev[d] = 1'b0; m_comp[d] = 1'b0; m_run[d] = 0;
            end else if (m_comp[d]) begin
                check(d, "gap_after_ack", 32'({cyc[d], stb[d], we[d]}), 32'd0);
                m_prev[d] = 1'b0; m_comp[d] = 1'b0; m_run[d] = 0;
            end else if (cyc[d]) begin
                check(d, "stb_with_cyc", 32'(stb[d]), 32'd1);
                if (m_prev[d]) check(d, "held_stable", 32'({adr[d], dat_o[d], we[d]}), 32'(m_hold[d]));
                m_hold[d] = {adr[d], dat_o[d], we[d]};
                m_run[d]  = m_run[d] + 1;
                m_prev[d] = 1'b1;
                if (ack[d]) begin
                    m_comp[d] = 1'b1;
                    score(d, 1'b0);
                end
            end else begin
                if (m_prev[d]) score(d, 1'b1);
                m_prev[d] = 1'b0; m_run[d] = 0;
            end
        end
    end

    task automatic launch(int d, int stall_at);
        stall[d] = stall_at;
        model_seq(d, stall_at);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check(d, "start_flags", 32'({busy[d], done[d], err[d]}), 32'b100);
    endtask

    task automatic finish_seq(int d, logic exp_err);
        int t;
        t = 0;
        while (!done[d] && !err[d] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #1;
        check(d, "seq_terminated", 32'(t < 2000), 32'd1);
        check(d, "end_flags", 32'({busy[d], done[d], err[d]}), 32'({1'b0, !exp_err, exp_err}));
        check(d, "scoreboard_drained", 32'(exp_size(d)), 32'd0);
        stall[d] = -1;
    endtask

    task automatic wait_access(int d, logic [2:0] a);
        int t;
        t = 0;
        while (!(cyc[d] && adr[d] == a) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(d, "reached_access", 32'(t < 500), 32'd1);
    endtask

    initial begin
        int   bad;
        int   n_busy;
        int   t;
        int   d;
        int   st;
        logic exp_err;

        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check(k, "reset_outputs",
                  32'({adr[k], dat_o[k], we[k], stb[k], cyc[k], busy[k], done[k], err[k]}), 32'd0);

        // Default build auto-starts; custom build must stay silent without start_i.
        model_seq(0, -1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cyc[1] || stb[1] || we[1] || busy[1] || done[1] || err[1]) bad++;
        end
        check(1, "no_autostart_idle", 32'(bad), 32'd0);
        finish_seq(0, 1'b0);

        // Zero-wait slave: twelve busy cycles then DONE.
        zero_wait = 1'b1;
        repeat (2) @(negedge clk);
        model_seq(0, -1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n_busy = 0;
        t = 0;
        while (!done[0] && t < 200) begin
            if (busy[0]) n_busy++;
            @(negedge clk);
            t++;
        end
        check(0, "zero_wait_busy_cycles", 32'(n_busy), 32'd12);
        finish_seq(0, 1'b0);
        zero_wait = 1'b0;

        // start_i during FCR is ignored; a single sequence completes.
        launch(0, -1);
        wait_access(0, 3'd2);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check(0, "busy_after_ignored_start", 32'(busy[0]), 32'd1);
        finish_seq(0, 1'b0);

        // Custom build: DLM never acked -> timeout of TO_B cycles, then restart succeeds.
        launch(1, 2);
        finish_seq(1, 1'b1);
        repeat (20) @(negedge clk);
        check(1, "quiet_after_error", 32'({cyc[1], busy[1], err[1]}), 32'b001);
        launch(1, -1);
        finish_seq(1, model_err(1, -1));

`ifdef UART_INIT_READBACK_EN
        rd_val[0] = 8'h07;
        launch(0, -1);
        finish_seq(0, 1'b1);
        rd_val[0] = 8'h03;
        launch(0, -1);
        finish_seq(0, 1'b0);
`endif

        // Reset while stalled in DLL, then auto-restart from LCR_DLAB.
        stall[0] = 1;
        push_exp(0, ref_access(0, 0));
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_access(0, 3'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check(0, "reset_mid_access",
              32'({cyc[0], stb[0], we[0], busy[0], done[0], err[0], adr[0], dat_o[0]}), 32'd0);
        check(0, "reset_scoreboard", 32'(exp_size(0)), 32'd0);
        stall[0] = -1;
        repeat (3) @(negedge clk);
        model_seq(0, -1);
        rst_n[0] = 1'b1;
        finish_seq(0, 1'b0);

        // Randomized runs with stray acks, random stalls and readback data.
        noise = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d  = k % 2;
            st = int'($urandom_range(0, N_ACC + 3));
            if (st >= N_ACC) st = -1;
            rd_val[d] = ($urandom_range(0, 1) == 0) ? (lcr_of(d) & 8'h7F) : ((lcr_of(d) & 8'h7F) ^ 8'h04);
            exp_err = model_err(d, st);
            launch(d, st);
            finish_seq(d, exp_err);
        end
        noise = 1'b0;

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_init_sequencer.md
UART_INIT_SEQUENCER -- requirements
Module: uart_init_sequencer

Interface
REQ-001 Parameter DIVISOR, default 16'h001B, baud divisor programmed into DLL/DLM.
REQ-002 Parameter LCR_VALUE, default 8'h03, line control (8N1); bit 7 ignored.
REQ-003 Parameter FCR_VALUE, default 8'hC7, FIFO control value.
REQ-004 Parameter IER_VALUE, default 8'h00, interrupt enable value.
REQ-005 Parameter TIMEOUT, default 64, max cycles waiting for ack per access (2..1023).
REQ-006 Parameter AUTO_START, default 1, start sequence automatically after reset release.
REQ-007 wb_clk_i  in  1  single clock, all logic posedge.
REQ-008 wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-009 start_i  in  1  one-cycle request to (re)run the sequence.
REQ-010 wb_adr_o  out  3  UART register address.
REQ-011 wb_dat_o  out  8  write data to UART.
REQ-012 wb_dat_i  in  8  read data from UART.
REQ-013 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone master controls.
REQ-014 wb_ack_i  in  1  Wishbone slave acknowledge.
REQ-015 busy_o  out  1  sequence in progress.
REQ-016 done_o  out  1  last sequence completed without error (sticky until next start).
REQ-017 err_o  out  1  last sequence aborted (timeout or readback mismatch; sticky until next start).

Function
REQ-018 States: IDLE, LCR_DLAB, DLL, DLM, LCR, FCR, IER, CHECK (macro only), GAP, DONE, ERROR.
REQ-019 Write order and values: adr 3 <- LCR_VALUE|8'h80; adr 0 <- DIVISOR[7:0]; adr 1 <- DIVISOR[15:8]; adr 3 <- LCR_VALUE&8'h7F; adr 2 <- FCR_VALUE; adr 1 <- IER_VALUE.
REQ-020 Each access: cyc=stb=1 with adr/dat/we stable from the cycle the state is entered until the cycle wb_ack_i is sampled 1.
REQ-021 Cycle after ack: cyc=stb=we=0 for exactly one GAP cycle, then next access begins; 6-write sequence with zero-wait ack completes in 12 cycles + 1 to DONE.
REQ-022 Ack sampled while cyc=0 is ignored.
REQ-023 Per-access cycle counter reset on access entry; reaching TIMEOUT without ack -> drop cyc/stb/we next cycle, enter ERROR, err_o=1, busy_o=0.
REQ-024 busy_o=1 from the cycle after start is accepted until DONE/ERROR entry.
REQ-025 start_i accepted only in IDLE, DONE or ERROR; clears done_o/err_o, enters LCR_DLAB next cycle; ignored while busy_o=1.
REQ-026 AUTO_START=1: first cycle after reset release acts as an accepted start; AUTO_START=0: waits in IDLE for start_i.
REQ-027 DONE and ERROR hold until next accepted start; no bus activity in IDLE/DONE/ERROR.

Reset
REQ-028 wb_rst_n_i low asynchronously forces IDLE; wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o = 0; wb_adr_o = 0; wb_dat_o = 0.
REQ-029 Reset mid-access drops cyc/stb immediately; no partial state retained; AUTO_START restarts from LCR_DLAB.

Configuration
REQ-030 Macro UART_INIT_READBACK_EN defined: after IER write and GAP, CHECK reads adr 3 (we=0) and compares wb_dat_i to LCR_VALUE&8'h7F at ack; equal -> DONE, unequal -> ERROR; timeout rule applies.
REQ-031 Macro undefined: CHECK state absent; IER write + GAP -> DONE; wb_dat_i unused.

Verification
REQ-032 Defaults, AUTO_START=1, slave acks next cycle -> writes (3,83),(0,1B),(1,00),(3,03),(2,C7),(1,00) in order, done_o=1, err_o=0.
REQ-033 Slave never acks DLM, TIMEOUT=8 -> cyc drops 8 cycles after DLM entry, err_o=1, done_o=0, no further writes.
REQ-034 Readback macro on, slave returns 8'h07 for LCR read -> err_o=1; returns 8'h03 -> done_o=1.
REQ-035 start_i pulsed during FCR write -> ignored, single sequence completes; start_i after DONE -> done_o clears, full sequence repeats.
REQ-036 wb_rst_n_i asserted while stb high in DLL -> same-timestep cyc/stb=0, busy_o=0; release with AUTO_START=1 -> sequence restarts at LCR_DLAB.
REQ-037 AUTO_START=0, no start_i for 100 cycles -> no bus activity, busy_o=0, done_o=0.
